// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: FSM states, default geometry,
// word/lane constants and the byte-lane merge used by both the array write
// path and the same-word read forwarding path.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH     = 16384;
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned LANES          = 4;
    localparam int unsigned WORD_W         = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } dmem_state_e;

    // Replace each byte lane whose enable is set with the new data's byte.
    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [LANES-1:0]  be
    );
        logic [WORD_W-1:0] r;
        r = old_w;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word array with one byte-enabled synchronous write port and one registered
// read port. Read data is read-before-write and holds until the next enabled
// read; rd_zero_i loads 0 instead of the array word.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANES-1:0]  wr_be_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              rd_en_i,
    input  logic              rd_zero_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Byte-masked array write; the array itself is cleared by the owner FSM.
    always_ff @(posedge clk) begin
        if (|wr_be_i) mem[waddr_i] <= lane_merge(mem[waddr_i], wdata_i, wr_be_i);
    end

    // Registered read port, zeroed on reset or on a rejected read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= rd_zero_i ? '0 : mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Data memory responder for the CPU data port. Zero-fills the array after
// every reset, then serves 1-cycle registered reads and byte-masked writes.
// Optional macro DMEM_RAW_FWD_EN: a same-edge read and write of one word
// returns the merged (post-write) word instead of the pre-write word.
module data_mem
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = DMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_read,
    input  logic [LANES-1:0]  data_write,
    input  logic [31:0]       data_addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              mem_busy,
    output logic              addr_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_state_e       state_q;
    logic [AW-1:0]     clr_idx_q;
    logic              busy_q;
    logic              addr_err_q;

    logic [31:0]       off;
    logic [31:0]       off_w;
    logic              in_range;
    logic [AW-1:0]     word_idx;
    logic              acc_ok;
    logic              rd_acc;
    logic              wr_acc;

    logic [LANES-1:0]  ram_be;
    logic [AW-1:0]     ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

    // Address decode: unsigned offset from the base, range check in words.
    always_comb begin
        off      = data_addr - BASE_ADDR;
        off_w    = off >> 2;
        in_range = off_w < 32'(DEPTH);
        word_idx = off_w[AW-1:0];
        acc_ok   = (state_q == IDLE) && !rst;
        rd_acc   = acc_ok && data_read;
        wr_acc   = acc_ok && (|data_write);
    end

    // Array write port: clear walker in CLEAR, accepted writes in IDLE.
    always_comb begin
        ram_be    = '0;
        ram_waddr = word_idx;
        ram_wdata = data_in;
        if (!rst) begin
            if (state_q == CLEAR) begin
                ram_be    = '1;
                ram_waddr = clr_idx_q;
                ram_wdata = '0;
            end else if (wr_acc && in_range) begin
                ram_be    = data_write;
            end
        end
    end

    // Clear/idle FSM with registered busy and sticky range-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_idx_q  <= '0;
            busy_q     <= 1'b1;
            addr_err_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        clr_idx_q <= '0;
                    end else begin
                        clr_idx_q <= clr_idx_q + AW'(1);
                    end
                end
                IDLE: begin
                    if ((rd_acc || wr_acc) && !in_range) addr_err_q <= 1'b1;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    dmem_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_be_i   (ram_be),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .rd_en_i   (rd_acc),
        .rd_zero_i (!in_range),
        .raddr_i   (word_idx),
        .rdata_o   (ram_rdata)
    );

`ifdef DMEM_RAW_FWD_EN
    logic              fwd_q;
    logic [WORD_W-1:0] fwd_data_q;
    logic [LANES-1:0]  fwd_be_q;

    // The RAM returns the pre-write word; remembering the colliding write
    // lets the merge be applied on the output, held until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
        end else if (rd_acc) begin
            fwd_q      <= in_range && (|data_write);
            fwd_data_q <= data_in;
            fwd_be_q   <= data_write;
        end
    end

    assign data_out = fwd_q ? lane_merge(ram_rdata, fwd_data_q, fwd_be_q) : ram_rdata;
`else
    assign data_out = ram_rdata;
`endif

    assign mem_busy = busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: the driver pushes expected read data when a
// read is issued; a monitor pops and compares one cycle after the request.
module tb_data_mem;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = DMEM_DEPTH;
    localparam logic [31:0] BASE  = DMEM_BASE_ADDR;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

`ifdef DMEM_RAW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        data_read;
    logic [3:0]  data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_busy;
    logic        addr_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic        mon_rd = 1'b0;

    data_mem #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .mem_busy   (mem_busy),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: a read sampled at a posedge is checked at the following negedge.
    always @(posedge clk) mon_rd <= (data_read === 1'b1) && (rst === 1'b0);

    always @(negedge clk) begin
        if (mon_rd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read actual=%h expected=none", data_out);
            end else begin
                chk(nm_q.pop_front(), data_out, exp_q.pop_front());
            end
        end
    end

    // One access cycle; reads queue their expected data for the monitor.
    task automatic access(input logic rd, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] din, input logic [31:0] exp, input string nm);
        @(negedge clk);
        data_read  = rd;
        data_write = we;
        data_addr  = addr;
        data_in    = din;
        if (rd) begin
            exp_q.push_back(exp);
            nm_q.push_back(nm);
        end
        @(negedge clk);
        data_read  = 1'b0;
        data_write = 4'b0000;
    endtask

    // Count cycles with rst low and mem_busy high; optionally try a write mid-clear.
    task automatic wait_clear(input bit inj, input string nm);
        int cnt = 0;
        while (mem_busy === 1'b1 && cnt <= int'(DEPTH) + 8) begin
            if (inj && cnt == 10) begin
                data_write = 4'b1111;
                data_addr  = 32'h0;
                data_in    = 32'hFFFF_FFFF;
            end else if (inj && cnt == 11) begin
                data_write = 4'b0000;
            end
            cnt++;
            @(negedge clk);
        end
        data_write = 4'b0000;
        chk(nm, 32'(cnt), 32'(DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        data_read  = 1'b0;
        data_write = 4'b0000;
        data_addr  = 32'h0;
        data_in    = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_dout", data_out, 32'h0);
        chk("rst_busy", 32'(mem_busy), 32'h1);
        chk("rst_err",  32'(addr_err), 32'h0);

        rst = 1'b0;
        wait_clear(1'b0, "clear_len");

        access(1'b1, 4'b0000, BASE + 32'd400, 32'h0, 32'h0, "rd_w100");

        access(1'b0, 4'b1111, BASE + 32'h40, 32'hDEAD_BEEF, 32'h0, "");
        access(1'b1, 4'b0000, BASE + 32'h40, 32'h0, 32'hDEAD_BEEF, "rd_full");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold", data_out, 32'hDEAD_BEEF);
        end

        access(1'b0, 4'b0010, BASE + 32'h40, 32'h0000_AB00, 32'h0, "");
        chk("wr_keeps_dout", data_out, 32'hDEAD_BEEF);
        access(1'b1, 4'b0000, BASE + 32'h40, 32'h0, 32'hDEAD_ABEF, "rd_lane1");
        chk("err_clean", 32'(addr_err), 32'h0);

        access(1'b1, 4'b0000, BASE + SPAN, 32'h0, 32'h0, "rd_oor");
        chk("err_set", 32'(addr_err), 32'h1);
        access(1'b0, 4'b1111, BASE, 32'h1, 32'h0, "");
        access(1'b1, 4'b0000, BASE, 32'h0, 32'h1, "rd_after_oor");
        access(1'b0, 4'b1111, BASE + SPAN + 32'h40, 32'hCAFE_F00D, 32'h0, "");
        access(1'b1, 4'b0000, BASE + 32'h40, 32'h0, 32'hDEAD_ABEF, "oor_wr_drop");

        access(1'b0, 4'b1111, BASE + SPAN - 32'd4, 32'hA5A5_5A5A, 32'h0, "");
        access(1'b1, 4'b0000, BASE + SPAN - 32'd4, 32'h0, 32'hA5A5_5A5A, "rd_last");

        access(1'b0, 4'b1111, BASE + 32'h80, 32'h1111_1111, 32'h0, "");
        access(1'b1, 4'b1111, BASE + 32'h80, 32'h2222_2222,
               FWD ? 32'h2222_2222 : 32'h1111_1111, "raw_full");
        access(1'b1, 4'b0000, BASE + 32'h80, 32'h0, 32'h2222_2222, "raw_commit");
        access(1'b1, 4'b0001, BASE + 32'h80, 32'h0000_00AA,
               FWD ? 32'h2222_22AA : 32'h2222_2222, "raw_lane");
        access(1'b1, 4'b0000, BASE + 32'h80, 32'h0, 32'h2222_22AA, "raw_lane_commit");
        chk("err_sticky", 32'(addr_err), 32'h1);

        // Reset, then interrupt the clear at counter index 50.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midclr_busy", 32'(mem_busy), 32'h1);
        chk("midclr_err",  32'(addr_err), 32'h0);
        chk("midclr_dout", data_out, 32'h0);
        rst = 1'b0;
        wait_clear(1'b1, "clear_restart");

        access(1'b1, 4'b0000, BASE, 32'h0, 32'h0, "rd_w0_cleared");
        access(1'b1, 4'b0000, BASE + 32'h80, 32'h0, 32'h0, "rd_w32_cleared");
        chk("err_after_rst", 32'(addr_err), 32'h0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
